alu_sched: RTL and testbench

Request scheduler that shares the single signed add/multiply datapath among `NREQ` requesters. It arbitrates one operation per cycle and drives the registered operand/opcode interface of the add/mult unit. It tracks each issued operation through the unit's fixed latency and returns the results in issue order, tagged with the requester index, through a credit-protected result FIFO.

---
 rtl/alu_sched_pkg.sv | 15 +
 rtl/alu_sched_fifo.sv | 52 +++++
 rtl/alu_sched.sv | 167 ++++++++++++++++
 tb/tb_alu_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants and FIFO entry type for the add/mult request scheduler.
package alu_sched_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int ALU_W   = 32;
  localparam int ALU_IDW = 1;

  typedef struct packed {
    logic [ALU_IDW-1:0] id;
    logic [ALU_W-1:0]   data;
  } entry_t;

endpackage

// File: rtl/alu_sched_fifo.sv
// Show-ahead synchronous result FIFO with full/empty flags.
module alu_sched_fifo
  import alu_sched_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = entry_t
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic do_pop;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign rdata  = mem[rp];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      end
      if (do_pop) begin
        rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      end
      cnt <= cnt + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Credit-based scheduler sharing one add/mult datapath among NREQ requesters.
// Define ALU_SCHED_RR_EN for round-robin arbitration; default is fixed priority.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int W     = ALU_W,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_op,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  output logic                     dp_valid,
  output logic                     dp_op,
  output logic [W-1:0]             dp_a,
  output logic [W-1:0]             dp_b,
  input  logic [W-1:0]             dp_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } ent_t;

  logic [CW-1:0] cred;
  logic          issue_ok;
  logic          hs;
  logic          pop;
  logic          gnt_any;
  logic [IW-1:0] gnt;
  logic [IW-1:0] idx;

`ifdef ALU_SCHED_RR_EN
  logic [IW-1:0] ptr;
  logic [IW:0]   sum;

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    idx     = '0;
    sum     = '0;
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, ptr} + (IW+1)'(j);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      idx = sum[IW-1:0];
      if (!gnt_any && req_valid[idx]) begin
        gnt     = idx;
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = IW'(j);
      if (!gnt_any && req_valid[idx]) begin
        gnt     = idx;
        gnt_any = 1'b1;
      end
    end
  end
`endif

  // A pop in the same cycle cannot unblock issue: only registered credit counts.
  assign issue_ok  = (cred != '0);
  assign req_ready = (rstn && issue_ok && gnt_any) ? (NREQ'(1) << gnt) : '0;
  assign hs        = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_valid <= 1'b0;
      dp_op    <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      dp_valid <= hs;
      if (hs) begin
        dp_op <= req_op[gnt];
        dp_a  <= req_a[int'(gnt)*W +: W];
        dp_b  <= req_b[int'(gnt)*W +: W];
      end
    end
  end

  logic [LAT:0]  tv;
  logic [IW-1:0] tid [LAT+1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tv <= '0;
      for (int i = 0; i <= LAT; i++) begin
        tid[i] <= '0;
      end
    end else begin
      tv     <= {tv[LAT-1:0], hs};
      tid[0] <= gnt;
      for (int i = 1; i <= LAT; i++) begin
        tid[i] <= tid[i-1];
      end
    end
  end

  logic push;
  logic full;
  logic empty;
  ent_t wdata;
  ent_t head;

  assign push  = tv[LAT];
  assign wdata = '{id: tid[LAT], data: dp_result};
  assign pop   = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cred <= CW'(DEPTH);
    end else begin
      cred <= cred - CW'(hs) + CW'(pop);
    end
  end

  alu_sched_fifo #(
    .DEPTH (DEPTH),
    .T     (ent_t)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign rsp_valid = !empty;
  assign rsp_id    = head.id;
  assign rsp_data  = head.data;

  no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && full));

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a 2-stage add/mult datapath model.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int NREQ  = 2;
  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_op;
  logic [63:0]     req_a;
  logic [63:0]     req_b;
  logic            dp_valid;
  logic            dp_op;
  logic [31:0]     dp_a;
  logic [31:0]     dp_b;
  logic [31:0]     dp_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_data;

  int checks = 0;
  int errors = 0;
  logic [32:0] expq [$];

  alu_sched #(
    .NREQ  (NREQ),
    .W     (W),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_valid  (dp_valid),
    .dp_op     (dp_op),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  logic [31:0] r1 = '0;
  logic [31:0] r2 = '0;
  always @(posedge clk) begin
    r1 <= (dp_op == OP_MUL) ? dp_a * dp_b : dp_a + dp_b;
    r2 <= r1;
  end
  assign dp_result = r2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp();
    logic [32:0] e;
    e = expq.pop_front();
    chk("rsp_id", 32'(rsp_id), 32'(e[32]));
    chk("rsp_data", rsp_data, e[31:0]);
  endtask

  task automatic collect(input int n, input int maxc);
    int got = 0;
    for (int c = 0; c < maxc && got < n; c++) begin
      #1;
      if (rsp_valid) begin
        chk_rsp();
        got++;
      end
      @(negedge clk);
    end
    chk("rsp_count", 32'(got), 32'(n));
  endtask

  logic        p_op [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] p_a  [6] = '{32'd1, 32'd10, 32'd3, 32'hFFFFFFFE, 32'd7, 32'd100};
  logic [31:0] p_b  [6] = '{32'd1, 32'd20, 32'd3, 32'd8, 32'd6, 32'd5};
  logic [31:0] p_r  [6] = '{32'd2, 32'd30, 32'd9, 32'hFFFFFFF0, 32'd42, 32'd105};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int j;
    int hi;
    int g [4];

    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dp_valid", 32'(dp_valid), 32'd0);
    chk("rst_dp_op", 32'(dp_op), 32'd0);
    chk("rst_dp_a", dp_a, 32'd0);
    chk("rst_dp_b", dp_b, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // single add, latency and hold behaviour
    @(negedge clk);
    req_valid  = 2'b01;
    req_op[0]  = OP_ADD;
    req_a[31:0] = 32'd3;
    req_b[31:0] = 32'd4;
    #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    expq.push_back({1'b0, 32'd7});
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t1_dp_valid", 32'(dp_valid), 32'd1);
    chk("t1_dp_op", 32'(dp_op), 32'(OP_ADD));
    chk("t1_dp_a", dp_a, 32'd3);
    chk("t1_dp_b", dp_b, 32'd4);
    chk("t1_rsp_early1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_dp_drop", 32'(dp_valid), 32'd0);
    chk("t1_dp_hold", dp_a, 32'd3);
    chk("t1_rsp_early2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_rsp_early3", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk_rsp();
    @(negedge clk);
    #1;
    chk("t1_rsp_drained", 32'(rsp_valid), 32'd0);

    // reset with work in flight and one result queued
    rsp_ready   = 1'b0;
    req_op[0]   = OP_ADD;
    req_a[31:0] = 32'd1;
    req_b[31:0] = 32'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 2'b01;
    end
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b0;
    #1;
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_dp_valid", 32'(dp_valid), 32'd0);
    chk("mr_dp_a", dp_a, 32'd0);
    chk("mr_dp_b", dp_b, 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rsp_ready = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) hi++;
    end
    chk("mr_stale_rsp", 32'(hi), 32'd0);

    // two requesters held valid
`ifdef ALU_SCHED_RR_EN
    g = '{0, 1, 0, 1};
`else
    g = '{0, 0, 1, 1};
`endif
    req_op       = {OP_ADD, OP_MUL};
    req_a[31:0]  = 32'hFFFFFFFB;
    req_b[31:0]  = 32'd16;
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef ALU_SCHED_RR_EN
      req_valid = 2'b11;
`else
      req_valid = (i >= 2) ? 2'b10 : 2'b11;
`endif
      #1;
      chk("t2_grant", 32'(req_ready), 32'd1 << g[i]);
      if (g[i] == 0) expq.push_back({1'b0, 32'hFFFFFFB0});
      else           expq.push_back({1'b1, 32'd7});
    end
    @(negedge clk);
    req_valid = '0;
    collect(4, 20);

    // credit exhaustion with the consumer stalled
    rsp_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid   = 2'b01;
      req_op[0]   = p_op[j];
      req_a[31:0] = p_a[j];
      req_b[31:0] = p_b[j];
      #1;
      if (req_ready[0]) begin
        expq.push_back({1'b0, p_r[j]});
        j++;
      end
    end
    chk("t3_accepted", 32'(j), 32'd4);
    chk("t3_ready_low", 32'(req_ready), 32'd0);
    chk("t3_rsp_held", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("t3_cred0_pop", 32'(req_ready), 32'd0);
    chk_rsp();
    @(negedge clk);
    #1;
    chk("t3_credit_ret1", 32'(req_ready), 32'd1);
    chk_rsp();
    expq.push_back({1'b0, p_r[4]});
    @(negedge clk);
    req_op[0]   = p_op[5];
    req_a[31:0] = p_a[5];
    req_b[31:0] = p_b[5];
    #1;
    chk("t3_credit_ret2", 32'(req_ready), 32'd1);
    chk_rsp();
    expq.push_back({1'b0, p_r[5]});
    @(negedge clk);
    req_valid = '0;
    #1;
    chk_rsp();
    @(negedge clk);
    collect(2, 12);
    chk("t3_queue_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
